serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 13 +
 rtl/serial_subtractor_if.sv | 26 ++
 rtl/serial_subtractor_cell.sv | 13 +
 rtl/serial_subtractor.sv | 99 +++++++++
 tb/tb_serial_subtractor.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // 2'd3 is unused; the FSM recovers from it to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between a requester (master) and the serial subtractor (slave).
interface serial_subtractor_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );

endinterface

// File: rtl/serial_subtractor_cell.sv
// Single-bit full subtractor: d = x - y - bin, bout set when the bit underflows.
module full_sub_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b: one full subtractor cell iterated LSB-first over WIDTH clocks.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, b_sh_q, d_sh_q, d_sh_d;
    logic [WIDTH-1:0]   diff_q;
    logic               bor_q, borrow_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               last;
    logic               cell_d, cell_bout;
    logic               busy, done;

    full_sub_cell u_cell (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (bor_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign last   = (cnt_q == CNT_W'(WIDTH - 1));
    assign d_sh_d = {cell_d, d_sh_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Result registers are written only on the final shift, so they hold across idle periods.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            d_sh_q   <= '0;
            bor_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_sh_q <= bus.a;
                        b_sh_q <= bus.b;
                        d_sh_q <= '0;
                        bor_q  <= 1'b0;
                        cnt_q  <= '0;
                    end
                end
                SHIFT: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    d_sh_q <= d_sh_d;
                    bor_q  <= cell_bout;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (last) begin
                        diff_q   <= d_sh_d;
                        borrow_q <= cell_bout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed vectors plus random back-to-back traffic.
module tb_serial_subtractor;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic cx, cy, cb, cd, cbo;
    full_sub_cell u_cell (.x(cx), .y(cy), .bin(cb), .d(cd), .bout(cbo));

    always #5 clk = ~clk;

    int unsigned  n_checks = 0;
    int unsigned  n_pass   = 0;
    int unsigned  n_accept = 0;
    int unsigned  n_done   = 0;
    int unsigned  busy_cnt = 0;
    logic [W:0]   exp_q[$];
    logic [W-1:0] hold_d = '0;
    logic         hold_b = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Timing model: accept only when idle; busy for WIDTH+1 cycles, done in the last one.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt = 0;
            exp_q.delete();
        end else if (busy_cnt == 0) begin
            if (bus.start) begin
                exp_q.push_back({bus.a < bus.b, bus.a - bus.b});
                n_accept++;
                busy_cnt = W + 1;
            end
        end else begin
            busy_cnt--;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            hold_d = '0;
            hold_b = 1'b0;
        end else begin
            chk("busy", 32'(bus.busy), 32'(busy_cnt != 0));
            chk("done", 32'(bus.done), 32'(busy_cnt == 1));
            if (bus.done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(1), 32'(0));
                end else begin
                    logic [W:0] e;
                    e = exp_q.pop_front();
                    hold_d = e[W-1:0];
                    hold_b = e[W];
                    chk("diff", 32'(bus.diff), 32'(hold_d));
                    chk("borrow_out", 32'(bus.borrow_out), 32'(hold_b));
                end
            end else begin
                chk("diff_hold", 32'(bus.diff), 32'(hold_d));
                chk("borrow_hold", 32'(bus.borrow_out), 32'(hold_b));
            end
        end
    end

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Called on the first negedge after the accept edge (cycle 1); returns the cycle done is seen.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!bus.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.done) chk("done_timeout", 32'(0), 32'(1));
    endtask

    typedef struct { logic [W-1:0] a; logic [W-1:0] b; } vec_t;
    vec_t vecs[4] = '{'{8'h00, 8'h01}, '{8'h03, 8'h05}, '{8'hFF, 8'hFF}, '{8'hFF, 8'h00}};

    initial begin
        int cyc;
        int unsigned base;
        int unsigned guard;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        #12;
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_diff", 32'(bus.diff), 32'(0));
        chk("rst_borrow", 32'(bus.borrow_out), 32'(0));
        @(negedge clk);
        #2 rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            int x, y, bi, r;
            x = (i >> 2) & 1; y = (i >> 1) & 1; bi = i & 1;
            cx = x[0]; cy = y[0]; cb = bi[0];
            r = x - y - bi;
            #1;
            chk("cell_d", 32'(cd), 32'(r & 1));
            chk("cell_bout", 32'(cbo), 32'(r < 0));
        end

        issue(8'h05, 8'h03);
        wait_done(cyc);
        chk("latency", 32'(cyc), 32'(9));

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b);
            wait_done(cyc);
        end

        // Start pulses during SHIFT and DONE must be ignored; held start lands after DONE.
        issue(8'h05, 8'h03);
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(cyc);
        bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h01;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(cyc);
        chk("b2b_latency", 32'(cyc), 32'(9));

        issue(8'h55, 8'h11);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'(0));
        chk("arst_done", 32'(bus.done), 32'(0));
        chk("arst_diff", 32'(bus.diff), 32'(0));
        chk("arst_borrow", 32'(bus.borrow_out), 32'(0));
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (12) @(negedge clk);

        issue(8'h80, 8'h7F);
        wait_done(cyc);

        base  = n_accept;
        guard = 0;
        while (n_accept < base + 1000 && guard < 40000) begin
            @(negedge clk);
            bus.start = 1'($urandom_range(0, 1));
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            guard++;
        end
        bus.start = 1'b0;
        if (n_accept < base + 1000) chk("random_timeout", 32'(0), 32'(1));

        repeat (W + 6) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        chk("done_count", 32'(n_done), 32'(n_accept - 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
